seg_count_display: RTL and testbench

SEG_COUNT_DISPLAY -- requirements
Module: seg_count_display

---
 rtl/seg_count_display.sv | 153 +++++++++++++++
 tb/tb_seg_count_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg_count_display.sv
// Free-running BCD up/down counter with a multiplexed active-low 7-segment scanner.
// Counting, clear and load share one tick divider; the scanner runs independently.
module seg_count_display #(
  parameter int NDIG     = 6,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              blank_lz,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   sel,
  output logic [4*NDIG-1:0] value,
  output logic              wrap
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  logic [TW-1:0]      r_tick_cnt;
  logic               w_tick;
  logic [SW-1:0]      r_scan_cnt;
  logic [IW-1:0]      r_idx;
  logic [4*NDIG-1:0]  w_next;
  logic [4*NDIG-1:0]  w_load_clean;
  logic               w_carry;
  logic [NDIG-1:0]    w_lz;
  logic               w_zrun;
  logic [3:0]         w_digit;
  logic               w_blank;

  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 8'hC0;
      4'd1:    seg_pat = 8'hF9;
      4'd2:    seg_pat = 8'hA4;
      4'd3:    seg_pat = 8'hB0;
      4'd4:    seg_pat = 8'h99;
      4'd5:    seg_pat = 8'h92;
      4'd6:    seg_pat = 8'h82;
      4'd7:    seg_pat = 8'hF8;
      4'd8:    seg_pat = 8'h80;
      4'd9:    seg_pat = 8'h90;
      default: seg_pat = 8'hFF;
    endcase
  endfunction

  assign w_tick = en && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (clr || load) begin
      r_tick_cnt <= '0;
    end else if (en) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    w_next       = value;
    w_load_clean = '0;
    w_carry      = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      w_load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
      if (w_carry) begin
        if (!dir) begin
          if (value[4*i +: 4] == 4'd9) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = value[4*i +: 4] + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (value[4*i +: 4] == 4'd0) begin
            w_next[4*i +: 4] = 4'd9;
          end else begin
            w_next[4*i +: 4] = value[4*i +: 4] - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        value <= '0;
      end else if (load) begin
        value <= w_load_clean;
      end else if (w_tick) begin
        value <= w_next;
        wrap  <= w_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // w_lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    w_lz    = '0;
    w_zrun  = 1'b1;
    w_digit = '0;
    w_blank = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      w_zrun = w_zrun && (value[4*(NDIG-1-i) +: 4] == 4'd0);
      w_lz[NDIG-1-i] = w_zrun;
    end
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (IW'(i) == r_idx) begin
        w_digit = value[4*i +: 4];
        w_blank = blank_lz && (i != 0) && w_lz[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      sel <= '1;
    end else begin
      seg <= w_blank ? 8'hFF : seg_pat(w_digit);
      sel <= ~(NDIG'(1) << r_idx);
    end
  end

endmodule

// File: tb/tb_seg_count_display.sv
// Directed bench for seg_count_display with NDIG=6, TICK_DIV=4, SCAN_DIV=2.
module tb_seg_count_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, dir, clr, load, blank_lz;
  logic [23:0] load_val;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic [23:0] value;
  logic        wrap;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  seg_count_display #(.NDIG(6), .TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .seg(seg), .sel(sel),
    .value(value), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    load_val = v;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  logic [7:0]  exp_seg [6];
  logic [5:0]  exp_sel;
  logic [5:0]  sel_before;
  int unsigned k;
  bit          found;

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0;
    blank_lz = 1'b0; load_val = '0;
    step(3);
    check("rst_value", value, 24'h000000);
    check("rst_wrap",  wrap,  1'b0);
    check("rst_seg",   seg,   8'hFF);
    check("rst_sel",   sel,   6'h3F);

    // Count up from reset: first tick after 4 cycles
    en = 1'b1; rst_n = 1'b1;
    step(3);
    check("up_pre", value, 24'h000000);
    step(1);
    check("up_1", value, 24'h000001);
    check("up_1_wrap", wrap, 1'b0);
    step(4);
    check("up_2", value, 24'h000002);

    // Up wrap from all nines
    do_load(24'h999998);
    check("ld_999998", value, 24'h999998);
    step(4);
    check("up_999999", value, 24'h999999);
    check("up_999999_wrap", wrap, 1'b0);
    step(4);
    check("up_wrap_val", value, 24'h000000);
    check("up_wrap_pulse", wrap, 1'b1);
    step(1);
    check("up_wrap_end", wrap, 1'b0);

    // Down wrap and borrow chain
    dir = 1'b1;
    do_load(24'h000000);
    step(4);
    check("dn_wrap_val", value, 24'h999999);
    check("dn_wrap_pulse", wrap, 1'b1);
    do_load(24'h100000);
    step(4);
    check("dn_borrow", value, 24'h099999);
    check("dn_borrow_wrap", wrap, 1'b0);

    // Pause mid-divider: value and divider frozen, scanning continues
    step(2);
    en = 1'b0;
    step(9);
    sel_before = sel;
    step(1);
    check("pause_value", value, 24'h099999);
    k = 0;
    for (int unsigned i = 0; i < 6; i++) if (!sel_before[i]) k = i;
    sel_before = sel;
    step(2);
    for (int unsigned i = 0; i < 6; i++) if (!sel_before[i]) k = i;
    exp_sel = ~(6'd1 << ((k + 1) % 6));
    check("pause_scan", sel, exp_sel);
    en = 1'b1;
    step(1);
    check("resume_hold", value, 24'h099999);
    step(1);
    check("resume_tick", value, 24'h099998);

    // clr beats load
    load_val = 24'h123456; clr = 1'b1; load = 1'b1;
    step(1);
    clr = 1'b0; load = 1'b0;
    check("clr_over_load", value, 24'h000000);
    check("clr_wrap", wrap, 1'b0);

    // Display with leading-zero blanking: d0=2, d1=4, upper four blank
    en = 1'b0; blank_lz = 1'b1;
    do_load(24'h000042);
    step(2);
    found = 1'b0;
    for (int unsigned t = 0; t < 20 && !found; t++) begin
      if (sel == 6'h3E) found = 1'b1;
      else step(1);
    end
    check("scan_sync", found, 1'b1);
    exp_seg = '{8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int unsigned d = 0; d < 6; d++) begin
      exp_sel = ~(6'd1 << d);
      check($sformatf("blank_sel%0d", d), sel, exp_sel);
      check($sformatf("blank_seg%0d", d), seg, exp_seg[d]);
      step(2);
    end
    blank_lz = 1'b0;
    exp_seg = '{8'hA4, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    for (int unsigned d = 0; d < 6; d++) begin
      exp_sel = ~(6'd1 << d);
      check($sformatf("noblank_sel%0d", d), sel, exp_sel);
      check($sformatf("noblank_seg%0d", d), seg, exp_seg[d]);
      step(2);
    end

    // Illegal BCD digit on load is stored as zero
    do_load(24'h12345C);
    check("ld_illegal", value, 24'h123450);

    // Asynchronous reset mid-scan
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg",   seg,   8'hFF);
    check("arst_sel",   sel,   6'h3F);
    check("arst_value", value, 24'h000000);
    step(1);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
